// File: rtl/mac_array_if.sv
// mac_array_if: term-in / row-out bundle between the DMA controller and mac_array.
// Carries one term per cycle (sof, ab_valid, A, B) and returns the finished row (C, valid, overrun).
// No backpressure: the array accepts one term every cycle, and results are single-cycle pulses.
interface mac_array_if #(
  parameter int N       = 6,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1
);
  logic                 sof;
  logic                 ab_valid;
  logic [N*WIDTH-1:0]   A;
  logic [WIDTH-1:0]     B;
  logic [N*M_WIDTH-1:0] C;
  logic [N-1:0]         valid;
  logic                 overrun;

  // master: term source (DMA side); slave: the MAC array
  modport master (output sof, ab_valid, A, B, input  C, valid, overrun);
  modport slave  (input  sof, ab_valid, A, B, output C, valid, overrun);
endinterface

// File: rtl/mac_array.sv
// mac_array: N-lane signed multiply-accumulate; N terms (A vector x shared B) form one dot-product row.
// Latency: last term -> valid/C 2 cycles, sof-abort -> overrun 1 cycle (both +1 with MAC_ARRAY_INPUT_REG_EN).
// No backpressure: one term accepted per cycle; valid/overrun are single-cycle pulses, C holds until the next row.
// Ports: clk, rst_n (async active-low); io (mac_array_if.slave): sof/ab_valid/A/B in, C/valid/overrun out.
// Optional: define MAC_ARRAY_INPUT_REG_EN to register sof/ab_valid/A/B before the multiply stage.
module mac_array #(
  parameter int N       = 6,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1
) (
  input  logic      clk,
  input  logic      rst_n,
  mac_array_if.slave io
);

  localparam int CW = $clog2(N+1);
  localparam int PW = 2*WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(N-1);

  // ---------------------------------------------------------------------------
  // Term source: direct or through an optional input register
  // ---------------------------------------------------------------------------
  logic               in_sof;
  logic               in_vld;
  logic [N*WIDTH-1:0] in_a;
  logic [WIDTH-1:0]   in_b;

`ifdef MAC_ARRAY_INPUT_REG_EN
  logic               in_sof_q;
  logic               in_vld_q;
  logic [N*WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0]   in_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sof_q <= 1'b0;
      in_vld_q <= 1'b0;
      in_a_q   <= '0;
      in_b_q   <= '0;
    end else begin
      in_sof_q <= io.sof;
      in_vld_q <= io.ab_valid;
      in_a_q   <= io.A;
      in_b_q   <= io.B;
    end
  end

  assign in_sof = in_sof_q;
  assign in_vld = in_vld_q;
  assign in_a   = in_a_q;
  assign in_b   = in_b_q;
`else
  assign in_sof = io.sof;
  assign in_vld = io.ab_valid;
  assign in_a   = io.A;
  assign in_b   = io.B;
`endif

  // ---------------------------------------------------------------------------
  // Term counter: 0 = idle, otherwise the number of terms taken so far
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          take;
  logic          first_d;
  logic          last_d;
  logic          ovr_d;

  always_comb begin
    cnt_d   = cnt_q;
    take    = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    ovr_d   = 1'b0;
    if (in_vld) begin
      if (in_sof) begin
        // sof always restarts; a partial row in progress is dropped
        take    = 1'b1;
        first_d = 1'b1;
        ovr_d   = (cnt_q != '0);
        if (N == 1) begin
          last_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d  = CW'(1);
        end
      end else if (cnt_q != '0) begin
        take = 1'b1;
        if (cnt_q == CNT_LAST) begin
          last_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
        end
      end
      // continuation with no row open: dropped, nothing changes
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers: counter, stage-1 tags, output pulses
  // ---------------------------------------------------------------------------
  logic s1_vld_q;
  logic s1_first_q;
  logic s1_last_q;
  logic valid_q;
  logic ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_vld_q   <= take;
      s1_first_q <= first_d;
      s1_last_q  <= last_d;
      valid_q    <= s1_vld_q & s1_last_q;
      ovr_q      <= ovr_d;
    end
  end

  assign io.valid   = {N{valid_q}};
  assign io.overrun = ovr_q;

  // ---------------------------------------------------------------------------
  // Per-lane datapath: multiply (stage 1), accumulate and publish (stage 2)
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] b_ext;
  assign b_ext = PW'($signed(in_b));

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic signed [WIDTH-1:0]   a_lane;
    logic signed [PW-1:0]      a_ext;
    logic signed [PW-1:0]      prod_d;
    logic signed [PW-1:0]      prod_q;
    logic signed [M_WIDTH-1:0] prod_sx;
    logic signed [M_WIDTH-1:0] acc_d;
    logic signed [M_WIDTH-1:0] acc_q;
    logic signed [M_WIDTH-1:0] c_q;

    assign a_lane = in_a[WIDTH*g +: WIDTH];
    // Operands are sign-extended to full product width so the multiply is exact
    assign a_ext   = PW'(a_lane);
    assign prod_d  = a_ext * b_ext;
    assign prod_sx = M_WIDTH'(prod_q);
    // A first-tagged product replaces the accumulator instead of adding to it
    assign acc_d   = s1_first_q ? prod_sx : acc_q + prod_sx;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        acc_q  <= '0;
        c_q    <= '0;
      end else begin
        if (take) begin
          prod_q <= prod_d;
        end
        if (s1_vld_q) begin
          acc_q <= acc_d;
          if (s1_last_q) begin
            c_q <= acc_d;
          end
        end
      end
    end

    assign io.C[M_WIDTH*g +: M_WIDTH] = c_q;
  end

endmodule
